// File: rtl/traffic_pkg.sv
// Shared encodings and helpers for the N-way traffic light controller family.
package traffic_pkg;

  localparam int unsigned LIGHT_W = 3;

  localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 3'b001;
  localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 3'b010;
  localparam logic [LIGHT_W-1:0] LIGHT_RED    = 3'b100;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  // Approach index width; a two-way controller still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/traffic_light_nway_rr_next_sel.sv
// Combinational round-robin picker: first demanding non-rest approach after cur, else rest road 0.
module rr_next_sel
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_APPROACH = 2,
  parameter int unsigned IDXW         = 1
) (
  input  logic [NUM_APPROACH-1:0] demand_i,
  input  logic [IDXW-1:0]         cur_i,
  output logic [IDXW-1:0]         next_o
);

  logic        found;
  int unsigned cand;

  // The current owner itself is never a candidate; it must yield to the rest road first.
  always_comb begin
    next_o = '0;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned k = 1; k < NUM_APPROACH; k++) begin
      cand = (32'(cur_i) + k) % NUM_APPROACH;
      if (!found && cand != 0 && demand_i[cand]) begin
        next_o = IDXW'(cand);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_light_nway.sv
// N-approach traffic light controller: latched demand, round-robin service, min/max green,
// yellow and all-red clearance. Approach 0 is the rest road.
module traffic_light_nway
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_APPROACH = 2,
  parameter int unsigned T_MIN_GREEN  = 4,
  parameter int unsigned T_MAX_GREEN  = 16,
  parameter int unsigned T_YELLOW     = 2,
  parameter int unsigned T_ALLRED     = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_APPROACH-1:0]                  sensor,
  output logic [LIGHT_W*NUM_APPROACH-1:0]          lights,
  output logic [idx_width(NUM_APPROACH)-1:0]       green_idx,
  output logic [1:0]                               phase
);

  localparam int unsigned IDXW  = idx_width(NUM_APPROACH);
  localparam int unsigned TMAXV = (T_MAX_GREEN > T_YELLOW) ?
                                  ((T_MAX_GREEN > T_ALLRED) ? T_MAX_GREEN : T_ALLRED) :
                                  ((T_YELLOW > T_ALLRED) ? T_YELLOW : T_ALLRED);
  localparam int unsigned TW    = $clog2(TMAXV + 1);

  phase_e                          state_q, state_d;
  logic [IDXW-1:0]                 idx_q, idx_d;
  logic [TW-1:0]                   timer_q, timer_d;
  logic [NUM_APPROACH-1:0]         demand_q, demand_d;
  logic [LIGHT_W*NUM_APPROACH-1:0] lights_q, lights_d;
  logic [IDXW-1:0]                 next_idx;
  logic                            owner_sensor;
  logic                            min_done;

  rr_next_sel #(
    .NUM_APPROACH (NUM_APPROACH),
    .IDXW         (IDXW)
  ) u_rr_next_sel (
    .demand_i (demand_q),
    .cur_i    (idx_q),
    .next_o   (next_idx)
  );

  // Next-state, timer, demand latch and light decode.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    demand_d     = demand_q;
    lights_d     = '0;
    owner_sensor = 1'b0;
    min_done     = (timer_q >= TW'(T_MIN_GREEN - 1));

    for (int unsigned i = 0; i < NUM_APPROACH; i++) begin
      if (idx_q == IDXW'(i)) owner_sensor = sensor[i];
    end

    case (state_q)
      PH_ALL_RED: begin
        if (timer_q == TW'(T_ALLRED - 1)) begin
          state_d = PH_GREEN;
          idx_d   = next_idx;
        end
      end
      PH_GREEN: begin
        if (idx_q == '0) begin
          if (min_done && (|demand_q)) state_d = PH_YELLOW;
        end else if ((min_done && !owner_sensor) || (timer_q == TW'(T_MAX_GREEN - 1))) begin
          state_d = PH_YELLOW;
        end
      end
      PH_YELLOW: begin
        if (timer_q == TW'(T_YELLOW - 1)) state_d = PH_ALL_RED;
      end
      default: state_d = PH_ALL_RED;
    endcase

    if (state_d != state_q)    timer_d = '0;
    else if (timer_q != '1)    timer_d = timer_q + TW'(1);

    // Clearing on GREEN entry overrides a same-cycle sensor set.
    for (int unsigned i = 0; i < NUM_APPROACH; i++) begin
      if (state_d == PH_GREEN && state_q != PH_GREEN && idx_d == IDXW'(i))
        demand_d[i] = 1'b0;
      else if (sensor[i] && !(state_q == PH_GREEN && idx_q == IDXW'(i)))
        demand_d[i] = 1'b1;

      lights_d[LIGHT_W*i +: LIGHT_W] = LIGHT_RED;
      if (idx_d == IDXW'(i)) begin
        if (state_d == PH_GREEN)       lights_d[LIGHT_W*i +: LIGHT_W] = LIGHT_GREEN;
        else if (state_d == PH_YELLOW) lights_d[LIGHT_W*i +: LIGHT_W] = LIGHT_YELLOW;
      end
    end
    demand_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PH_ALL_RED;
      idx_q    <= '0;
      timer_q  <= '0;
      demand_q <= '0;
      lights_q <= {NUM_APPROACH{LIGHT_RED}};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      demand_q <= demand_d;
      lights_q <= lights_d;
    end
  end

  assign lights    = lights_q;
  assign green_idx = idx_q;
  assign phase     = state_q;

endmodule
